mem_port_arbiter: RTL

//  Shares one single-port unified memory between the pipeline's instruction-fetch (IF) and data-memory (DM/MEM stage) requesters.

---
 rtl/mem_port_arbiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// Shares one single-port memory between instruction fetch (IF) and data memory (DM) requesters.
// Latency: gnt/mem_en one cycle after the request is sampled, valid MEM_LAT+2 cycles after it; one access in flight.
// Backpressure: requests are sampled only when no access is in flight; requesters hold req, stall_* track pending work.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] LAT_LAST   = 4'(MEM_LAT);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        starve_q, starve_d;
  logic              owner_dm_q, owner_dm_d;
  logic              we_q, we_d;
  logic              if_gnt_q, if_gnt_d;
  logic              dm_gnt_q, dm_gnt_d;
  logic              if_valid_q, if_valid_d;
  logic              dm_valid_q, dm_valid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic can_arb;
  logic pick_if;
  logic pick_dm;

  // Grant decision: DONE is also a decision cycle so back-to-back accesses run every MEM_LAT+2 cycles.
  always_comb begin
    can_arb = (state_q == ST_IDLE) || (state_q == ST_DONE);
    pick_if = can_arb && if_req && (!dm_req || (starve_q == STARVE_LIM));
    pick_dm = can_arb && dm_req && !pick_if;
  end

  // Next-state and output computation for the access FSM and the IF starvation counter.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_dm_d  = owner_dm_q;
    we_d        = we_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_gnt_d    = 1'b0;
    dm_gnt_d    = 1'b0;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (pick_if) begin
          state_d    = ST_BUSY;
          cnt_d      = 4'd0;
          owner_dm_d = 1'b0;
          we_d       = 1'b0;
          if_gnt_d   = 1'b1;
          mem_en_d   = 1'b1;
          mem_addr_d = if_addr;
        end else if (pick_dm) begin
          state_d     = ST_BUSY;
          cnt_d       = 4'd0;
          owner_dm_d  = 1'b1;
          we_d        = dm_we;
          dm_gnt_d    = 1'b1;
          mem_en_d    = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
        end
      end
      ST_BUSY: begin
        if (cnt_q == LAT_LAST) begin
          // mem_rdata is valid in this cycle; writes leave dm_rdata untouched
          state_d = ST_DONE;
          if (owner_dm_q) begin
            dm_valid_d = 1'b1;
            if (!we_q) begin
              dm_rdata_d = mem_rdata;
            end
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Counts DM wins while IF is waiting; IF is forced through once the limit is reached.
    starve_d = starve_q;
    if (!if_req || pick_if) begin
      starve_d = 4'd0;
    end else if (pick_dm && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // State registers; reset aborts any in-flight access and discards its response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      starve_q    <= 4'd0;
      owner_dm_q  <= 1'b0;
      we_q        <= 1'b0;
      if_gnt_q    <= 1'b0;
      dm_gnt_q    <= 1'b0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      owner_dm_q  <= owner_dm_d;
      we_q        <= we_d;
      if_gnt_q    <= if_gnt_d;
      dm_gnt_q    <= dm_gnt_d;
      if_valid_q  <= if_valid_d;
      dm_valid_q  <= dm_valid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign dm_gnt    = dm_gnt_q;
  assign if_valid  = if_valid_q;
  assign dm_valid  = dm_valid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Stalls are masked during reset so every output reads low while rst is held.
  assign stall_if  = if_req & ~if_valid_q & ~rst;
  assign stall_mem = dm_req & ~dm_valid_q & ~rst;

endmodule
